// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int ADDR_W = 8;
    localparam int INST_W = 32;

    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    // Sequential successor of a fetch address; wraps modulo 2^ADDR_W and is
    // deliberately left unclamped so the PC can apply its own negative-to-zero rule.
    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] addr);
        return addr + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_inst_buffer.sv
// One-entry holding register presenting a fetched instruction to decode.
module fetch_inst_buffer
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [INST_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    // Capture on load, drop the valid flag on clear; payload stays put otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_valid <= 1'b0;
            inst_data  <= '0;
            inst_pc    <= '0;
        end else if (load) begin
            inst_valid <= 1'b1;
            inst_data  <= load_data;
            inst_pc    <= load_pc;
        end else if (clear) begin
            inst_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: drives the PC's next address, requests instruction words
// from memory and hands them to decode through a one-entry buffer.
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] curr_addr,
    output logic [ADDR_W-1:0] next_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target
);

    fetch_state_t state;
    logic         load_buf;
    logic         clear_buf;

    // Buffer control: a response is kept only if no redirect kills it in the same cycle;
    // a held instruction leaves on handshake or on redirect.
    always_comb begin
        load_buf  = (state == WAIT) && imem_rvalid && !redirect_valid;
        clear_buf = (state == HOLD) && (inst_ready || redirect_valid);
    end

    // Memory request decodes from state only, so inst_ready never reaches imem_req.
    always_comb begin
        imem_req  = rst_n && (state == REQ);
        imem_addr = curr_addr;
    end

    // Next-PC mux: reset, then redirect, then sequential step on an accepted response, else hold.
    always_comb begin
        next_addr = curr_addr;
        if (!rst_n) begin
            next_addr = RESET_PC;
        end else if (redirect_valid) begin
            next_addr = redirect_target;
        end else if (load_buf) begin
            next_addr = step_addr(curr_addr);
        end
    end

    // Fetch FSM; DRAIN absorbs the response of a request orphaned by a redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= REQ;
        end else begin
            case (state)
                REQ: begin
                    state <= redirect_valid ? DRAIN : WAIT;
                end
                WAIT: begin
                    if (redirect_valid) begin
                        state <= imem_rvalid ? REQ : DRAIN;
                    end else if (imem_rvalid) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid || inst_ready) begin
                        state <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    fetch_inst_buffer u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_buf),
        .clear      (clear_buf),
        .load_data  (imem_rdata),
        .load_pc    (curr_addr),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: models the program counter and a variable-latency
// instruction memory, and checks the DUT every cycle against a transaction-level model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  curr_addr = 8'hFC;
    logic [7:0]  next_addr;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [7:0]  inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_target = '0;

    fetch_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .curr_addr       (curr_addr),
        .next_addr       (next_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int lat    = 1;
    bit lat_rand = 1'b0;
    bit armed    = 1'b0;

    typedef struct packed {
        int          due;
        logic [31:0] data;
    } mem_rsp_t;
    mem_rsp_t memq[$];

    typedef struct packed {
        int          at;
        logic [7:0]  pc;
        logic [31:0] data;
    } hs_t;
    hs_t hs_q[$];

    // Transaction-level reference: is a fetch in flight, will its answer be thrown
    // away, and what (if anything) is waiting for decode.
    bit          m_out   = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_held  = 1'b0;
    logic [31:0] m_data  = '0;
    logic [7:0]  m_ipc   = '0;

    function automatic logic [31:0] memword(input logic [7:0] a);
        if (a == 8'h00) return 32'h0000_0013;
        if (a == 8'h04) return 32'h0010_0093;
        return {a, 8'hC3, ~a, a ^ 8'h5A};
    endfunction

    function automatic bit model_req();
        return rst_n && !m_out && !m_held;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Environment and model advance on the clock: PC register, memory, reference.
    always @(posedge clk) begin
        int l;
        curr_addr <= next_addr[7] ? 8'h00 : next_addr;
        if (!rst_n) begin
            memq.delete();
            armed   <= 1'b1;
            m_out   <= 1'b0;
            m_stale <= 1'b0;
            m_held  <= 1'b0;
            m_data  <= '0;
            m_ipc   <= '0;
        end else begin
            if (imem_rvalid && memq.size() > 0 && memq[0].due == cyc) void'(memq.pop_front());
            if (imem_req) begin
                l = lat_rand ? int'($urandom_range(1, 4)) : lat;
                memq.push_back('{due: cyc + l, data: memword(imem_addr)});
            end
            if (model_req()) begin
                m_out   <= 1'b1;
                m_stale <= redirect_valid;
            end else if (m_out && imem_rvalid) begin
                m_out   <= 1'b0;
                m_stale <= 1'b0;
                if (!m_stale && !redirect_valid) begin
                    m_held <= 1'b1;
                    m_data <= imem_rdata;
                    m_ipc  <= curr_addr;
                end
            end else if (m_out && redirect_valid) begin
                m_stale <= 1'b1;
            end
            if (m_held && (inst_ready || redirect_valid)) m_held <= 1'b0;
        end
        cyc <= cyc + 1;
    end

    // Per-cycle comparison against the model, sampled mid-way through the low phase.
    always @(negedge clk) begin
        logic [7:0] exp_next;
        #2;
        if (armed) begin
            if (!rst_n)                                    exp_next = 8'h00;
            else if (redirect_valid)                       exp_next = redirect_target;
            else if (m_out && !m_stale && imem_rvalid)     exp_next = curr_addr + 8'd4;
            else                                           exp_next = curr_addr;
            chk("next_addr", 32'(next_addr), 32'(exp_next));
            chk("imem_req", 32'(imem_req), 32'(model_req()));
            if (model_req()) chk("imem_addr", 32'(imem_addr), 32'(curr_addr));
            chk("inst_valid", 32'(inst_valid), 32'(m_held));
            chk("inst_data", inst_data, m_data);
            chk("inst_pc", 32'(inst_pc), 32'(m_ipc));
            if (inst_valid && inst_ready) hs_q.push_back('{at: cyc, pc: inst_pc, data: inst_data});
        end
    end

    task automatic tick(input logic rst, input logic rdy, input logic rv,
                        input logic [7:0] tgt, input logic inj);
        @(negedge clk);
        rst_n           = rst;
        inst_ready      = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        if (memq.size() > 0 && memq[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memq[0].data;
        end else if (inj) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    endtask

    task automatic wait_req(input logic rdy, output logic [7:0] a);
        bit ok = 1'b0;
        a = 8'hxx;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick(1'b1, rdy, 1'b0, 8'h00, 1'b0);
            #2;
            if (imem_req) begin
                ok = 1'b1;
                a  = imem_addr;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_req: no imem_req within 60 cycles, got none, expected one");
        end
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            #2;
            if (inst_valid) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_valid: inst_valid not seen within 60 cycles, got 0, expected 1");
        end
    endtask

    initial begin
        logic [7:0]  a;
        logic [7:0]  p0;
        logic [31:0] d0;
        int          n0;

        // Reset release from the PC's power-up value.
        #1;
        chk("pwrup_curr", 32'(curr_addr), 32'hFC);
        chk("rst_next", 32'(next_addr), 32'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #2 chk("rst_curr", 32'(curr_addr), 32'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        lat = 1;
        tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        #2;
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", 32'(imem_addr), 32'h00);

        // Sequential fetch at L=1 with decode always ready.
        hs_q.delete();
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("seq_count", 32'(hs_q.size() >= 3), 32'h1);
        if (hs_q.size() >= 3) begin
            chk("seq_pc0", 32'(hs_q[0].pc), 32'h00);
            chk("seq_pc1", 32'(hs_q[1].pc), 32'h04);
            chk("seq_pc2", 32'(hs_q[2].pc), 32'h08);
            chk("seq_d0", hs_q[0].data, 32'h0000_0013);
            chk("seq_d1", hs_q[1].data, 32'h0010_0093);
            chk("seq_rate", 32'(hs_q[1].at - hs_q[0].at), 32'd3);
            chk("seq_rate2", 32'(hs_q[2].at - hs_q[1].at), 32'd3);
        end

        // Decode backpressure holds everything still.
        wait_valid();
        p0 = inst_pc;
        d0 = inst_data;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            #2;
            chk("bp_req", 32'(imem_req), 32'h0);
            chk("bp_pc", 32'(inst_pc), 32'(p0));
            chk("bp_data", inst_data, d0);
            chk("bp_curr", 32'(curr_addr), 32'(p0 + 8'd4));
        end

        // Redirect one cycle after a request with L=3.
        lat = 3;
        wait_req(1'b1, a);
        tick(1'b1, 1'b1, 1'b1, 8'h40, 1'b0);
        wait_req(1'b1, a);
        chk("wait_redir_addr", 32'(a), 32'h40);
        wait_valid();
        chk("wait_redir_pc", 32'(inst_pc), 32'h40);
        chk("wait_redir_data", inst_data, memword(8'h40));

        // Redirect together with the handshake in HOLD.
        n0 = hs_q.size();
        tick(1'b1, 1'b1, 1'b1, 8'h20, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        #2;
        chk("hold_consumed", 32'(hs_q.size()), 32'(n0 + 1));
        if (hs_q.size() > n0) chk("hold_consumed_pc", 32'(hs_q[n0].pc), 32'h40);
        chk("hold_redir_req", 32'(imem_req), 32'h1);
        chk("hold_redir_addr", 32'(imem_addr), 32'h20);

        // Sequential wrap at the top of the fetch space.
        lat = 1;
        tick(1'b1, 1'b1, 1'b1, 8'h7C, 1'b0);
        wait_req(1'b1, a);
        chk("wrap_req", 32'(a), 32'h7C);
        wait_valid();
        chk("wrap_pc", 32'(inst_pc), 32'h7C);
        chk("wrap_curr", 32'(curr_addr), 32'h00);
        wait_req(1'b1, a);
        chk("wrap_next", 32'(a), 32'h00);

        // Negative redirect target is passed through and lands at 0.
        tick(1'b1, 1'b1, 1'b1, 8'h90, 1'b0);
        #2 chk("neg_next", 32'(next_addr), 32'h90);
        wait_req(1'b1, a);
        chk("neg_req", 32'(a), 32'h00);

        // Reset while a fetch is outstanding; a stray response in the first REQ cycle is dropped.
        lat = 3;
        wait_req(1'b1, a);
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        #2;
        chk("rst_mid_req", 32'(imem_req), 32'h1);
        chk("rst_mid_addr", 32'(imem_addr), 32'h00);
        wait_valid();
        chk("rst_mid_pc", 32'(inst_pc), 32'h00);
        chk("rst_mid_data", inst_data, 32'h0000_0013);

        // Randomized traffic: latency, backpressure, redirects and the odd reset.
        lat_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 399) != 0), ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 9) == 0), 8'($urandom), 1'b0);
        end
        tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller on the other side of the `program_counter` interface. It consumes the PC's `curr_addr`, fetches the word at that address from instruction memory over a request/response handshake, and presents it to decode through a valid/ready handshake. Every cycle it drives `next_addr` back into the PC: hold, sequential step, or branch/jump redirect. The PC loads `next_addr` on every rising edge, so this block is the PC's only stall and redirect mechanism.

## Interface
- ADDR_W, 8: PC/address width. `next_addr` is interpreted as signed by the PC.
- INST_W, 32: instruction word width.
- PC_STEP, 4: sequential increment.

- clk  in  1  clock shared with `program_counter`
- rst_n  in  1  synchronous, active-low reset
- curr_addr  in  ADDR_W  current PC value
- next_addr  out  ADDR_W  value the PC loads on the next edge
- imem_req  out  1  fetch request, one-cycle pulse
- imem_addr  out  ADDR_W  fetch address, valid while `imem_req`=1
- imem_rvalid  in  1  memory response valid, one-cycle pulse, at least 1 cycle after `imem_req`
- imem_rdata  in  INST_W  fetched word, valid with `imem_rvalid`
- inst_valid  out  1  instruction held for decode
- inst_data  out  INST_W  held instruction
- inst_pc  out  ADDR_W  address the held instruction was fetched from
- inst_ready  in  1  decode accepts the held instruction
- redirect_valid  in  1  taken branch/jump, one-cycle pulse
- redirect_target  in  ADDR_W  redirect address

## Operation
- FSM states: REQ, WAIT, HOLD, DRAIN.
- **REQ:** `imem_req`=1, `imem_addr`=`curr_addr`, `next_addr`=`curr_addr` (hold). Next state is WAIT.
- **WAIT:** `next_addr`=`curr_addr`.
  - On `imem_rvalid`: capture `imem_rdata` into `inst_data` and `curr_addr` into `inst_pc`; set `inst_valid`; drive `next_addr`=`curr_addr`+PC_STEP (mod 2^ADDR_W). Next state is HOLD.
- **HOLD:** `next_addr`=`curr_addr` (the PC has already advanced).
  - On `inst_valid && inst_ready`: clear `inst_valid`. Next state is REQ.
- **DRAIN:** `next_addr`=`curr_addr`, no request issued.
  - On `imem_rvalid`: discard the data. Next state is REQ.
- **Redirect** has priority over every other `next_addr` source, in any state: `next_addr`=`redirect_target` and `inst_valid` clears next cycle.
  - From WAIT without `imem_rvalid` in the same cycle: next state is DRAIN.
  - From WAIT with `imem_rvalid` in the same cycle: the response is discarded. Next state is REQ.
  - From REQ: the issued request is outstanding. Next state is DRAIN.
  - From HOLD or DRAIN: next state is REQ (if DRAIN, only when `imem_rvalid` arrives that cycle; otherwise stay in DRAIN).
- **Redirect with `inst_ready` in the same HOLD cycle:** the handshake completes (the instruction is consumed) and the redirect is applied.
- **Width rules:**
  - `next_addr` is passed to the PC unclamped. The PC maps negative values (bit 7 set) to 0.
  - Sequential step from 0x7C yields 0x80, which the PC loads as 0. The effective fetch space is therefore 0x00–0x7C.
  - A redirect target with bit 7 set lands at 0.

## Timing
- **During reset:** `next_addr`=0x00, so the PC leaves its power-up value 0xFC and holds 0 after the first reset edge.
  - Other outputs in reset: `imem_req`=0, `inst_valid`=0, `inst_data`=0, `inst_pc`=0.
  - State after reset is REQ.
- **Reset mid-operation:** an outstanding memory response is ignored. Any `imem_rvalid` arriving in the first post-reset REQ cycle is dropped.
- **Registered outputs:** `inst_valid`, `inst_data`, `inst_pc`.
- **Combinational outputs:** `imem_req`, `imem_addr`, `next_addr`. These decode from state, `curr_addr`, `imem_rvalid` and `redirect_valid`; there is no combinational path from `inst_ready` to `imem_req`.
- **Latency:** with memory latency L ≥ 1, `inst_valid` rises L+1 cycles after entering REQ.
- **Throughput:** one instruction per L+2 cycles when `inst_ready` is held high.
- **Decode handshake:** `inst_data` and `inst_pc` are stable while `inst_valid`=1 and `inst_ready`=0.

## Structure
- **Package `fetch_pkg`:**
  - State enum: REQ, WAIT, HOLD, DRAIN.
  - Constants: ADDR_W, INST_W, PC_STEP, RESET_PC=0.
- **Sub-module `fetch_inst_buffer`:** one-entry holding register with load, clear and valid. It owns `inst_valid`, `inst_data` and `inst_pc`.
- **`fetch_sequencer`** owns the FSM and the `next_addr` mux.
- Integration: instantiate `fetch_sequencer` alongside `program_counter`, wired `curr_addr` → `curr_addr` and `next_addr` → `next_addr`.

## Test plan
- **Reset release:** PC starts at 0xFC, `rst_n` low for 2 cycles → `next_addr`=0, `curr_addr`=0 after the first edge, first `imem_req` with `imem_addr`=0x00.
- **Sequential fetch:** L=1, `inst_ready`=1, memory returns 0x00000013 at 0x00, 0x00100093 at 0x04 → `inst_pc` sequence 0x00, 0x04, 0x08, one instruction per 3 cycles.
- **Decode backpressure:** `inst_ready`=0 for 5 cycles in HOLD → `inst_data`, `inst_pc` and `curr_addr` (=`inst_pc`+4) stable, no `imem_req`.
- **Redirect in WAIT:** L=3, `redirect_valid` with target 0x40 one cycle after the request → stale response discarded, next request at 0x40, `inst_valid` never shows the stale word.
- **Redirect in HOLD:** redirect with `inst_ready`=1 in the same HOLD cycle (target 0x20) → the held instruction is consumed that cycle, next fetch at 0x20.
- **Wrap and negative target:**
  - Sequential fetch at 0x7C → PC becomes 0, next fetch at 0x00.
  - Redirect to 0x90 → fetch at 0x00.
